// File: rtl/rx_pattern_checker.sv
// Frame-sync and bit-error checker for sliced MSK data: finds the sync word (either polarity), verifies a period, counts errors in LOCK.
// Latency: 1 cycle from data_val_i to every output; accepts a bit every cycle and never stalls the source.
module rx_pattern_checker #(
    parameter int              PW       = 256,
    parameter logic [PW-1:0]   PATTERN  = 256'h9010_0000_0033_0000_00FF_FFFF_FF01_0000_0077_00FF_FF00_0000_0101_0000_FFA5_0FFE,
    parameter int              SYNC_W   = 32,
    parameter int              SYNC_ERR = 0,
    parameter int              LOSS_THR = 8,
    parameter int              CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      data_i,
    input  logic                      data_val_i,
    input  logic                      clear_i,
    output logic                      locked_o,
    output logic                      inverted_o,
    output logic                      err_pulse_o,
    output logic [$clog2(PW+1)-1:0]   period_err_o,
    output logic [CNT_W-1:0]          bit_cnt_o,
    output logic [CNT_W-1:0]          err_cnt_o,
    output logic [15:0]               loss_cnt_o
);

    localparam int PE_W  = $clog2(PW+1);
    localparam int PTR_W = $clog2(PW);
    localparam int MM_W  = $clog2(SYNC_W+1);
    localparam logic [SYNC_W-1:0] SYNC_WORD = PATTERN[PW-1 -: SYNC_W];
    localparam logic [PTR_W-1:0]  PTR_INIT  = PTR_W'(SYNC_W % PW);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PW-1);

    typedef enum logic [1:0] {S_SEARCH, S_VERIFY, S_LOCK} state_t;

    function automatic logic [MM_W-1:0] popcnt(input logic [SYNC_W-1:0] v);
        logic [MM_W-1:0] n;
        n = '0;
        for (int i = 0; i < SYNC_W; i++) n = n + MM_W'(v[i]);
        return n;
    endfunction

    state_t              r_state, w_state_nxt;
    // The oldest search bit only ever feeds the candidate word, so it is not stored.
    logic [SYNC_W-2:0]   r_sr;
    logic [PTR_W-1:0]    r_ptr, r_per_cnt;
    logic [PE_W-1:0]     r_per_err, r_period_err;
    logic                r_inv, r_locked, r_err_pulse;
    logic [CNT_W-1:0]    r_bit_cnt, r_err_cnt;
    logic [15:0]         r_loss_cnt;

    logic [SYNC_W-1:0]   w_cand;
    logic [MM_W-1:0]     w_m0, w_m1;
    logic                w_hit0, w_hit1;
    logic [PTR_W-1:0]    w_pat_idx;
    logic                w_err, w_period_end, w_over;
    logic [PE_W-1:0]     w_per_err_fin;
    logic                w_enter, w_track, w_in_lock, w_loss;

    assign w_cand        = {r_sr, data_i};
    assign w_m0          = popcnt(w_cand ^ SYNC_WORD);
    assign w_m1          = popcnt(w_cand ^ ~SYNC_WORD);
    assign w_hit0        = int'(w_m0) <= SYNC_ERR;
    assign w_hit1        = int'(w_m1) <= SYNC_ERR;
    assign w_pat_idx     = PTR_LAST - r_ptr;
    assign w_err         = data_i ^ PATTERN[w_pat_idx] ^ r_inv;
    assign w_per_err_fin = r_per_err + PE_W'(w_err);
    assign w_period_end  = (r_per_cnt == PTR_LAST);
    assign w_over        = int'(w_per_err_fin) > LOSS_THR;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_SEARCH;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (data_val_i) begin
            case (r_state)
                S_SEARCH: if (w_hit0 || w_hit1) w_state_nxt = S_VERIFY;
                S_VERIFY: if (w_period_end) w_state_nxt = w_over ? S_SEARCH : S_LOCK;
                S_LOCK:   if (w_period_end && w_over) w_state_nxt = S_SEARCH;
                default:  w_state_nxt = S_SEARCH;
            endcase
        end
    end

    always_comb begin
        w_enter   = data_val_i && (r_state == S_SEARCH) && (w_hit0 || w_hit1);
        w_track   = data_val_i && ((r_state == S_VERIFY) || (r_state == S_LOCK));
        w_in_lock = data_val_i && (r_state == S_LOCK);
        w_loss    = w_in_lock && w_period_end && w_over;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr         <= '0;
            r_ptr        <= '0;
            r_per_cnt    <= '0;
            r_per_err    <= '0;
            r_period_err <= '0;
            r_inv        <= 1'b0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
        end else begin
            if (data_val_i) r_sr <= w_cand[SYNC_W-2:0];
            if (w_enter) begin
                r_ptr     <= PTR_INIT;
                r_per_cnt <= '0;
                r_per_err <= '0;
                r_inv     <= ~w_hit0;
            end else if (w_track) begin
                r_ptr     <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
                r_per_cnt <= w_period_end ? '0 : r_per_cnt + 1'b1;
                r_per_err <= w_period_end ? '0 : w_per_err_fin;
                if (w_period_end) r_period_err <= w_per_err_fin;
                if (w_state_nxt == S_SEARCH) r_inv <= 1'b0;
            end
            r_locked    <= (w_state_nxt == S_LOCK);
            r_err_pulse <= w_in_lock && w_err;
        end
    end

    // Clear wins over a same-cycle increment; saturate instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt  <= '0;
            r_err_cnt  <= '0;
            r_loss_cnt <= '0;
        end else if (clear_i) begin
            r_bit_cnt  <= '0;
            r_err_cnt  <= '0;
            r_loss_cnt <= '0;
        end else begin
            if (w_in_lock && !(&r_bit_cnt))          r_bit_cnt  <= r_bit_cnt + 1'b1;
            if (w_in_lock && w_err && !(&r_err_cnt)) r_err_cnt  <= r_err_cnt + 1'b1;
            if (w_loss && !(&r_loss_cnt))            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign locked_o     = r_locked;
    assign inverted_o   = r_inv;
    assign err_pulse_o  = r_err_pulse;
    assign period_err_o = r_period_err;
    assign bit_cnt_o    = r_bit_cnt;
    assign err_cnt_o    = r_err_cnt;
    assign loss_cnt_o   = r_loss_cnt;

endmodule

// File: tb/tb_rx_pattern_checker.sv
// Scoreboard bench for rx_pattern_checker: reference model predicts outputs per cycle, monitor compares.
module tb_rx_pattern_checker;

    localparam int PW = 256;
    localparam int SYNC_W = 32;
    localparam int SYNC_ERR = 0;
    localparam int LOSS_THR = 8;
    localparam logic [255:0] PAT_C =
        256'h9010_0000_0033_0000_00FF_FFFF_FF01_0000_0077_00FF_FF00_0000_0101_0000_FFA5_0FFE;
    localparam int MD_SEARCH = 0, MD_VERIFY = 1, MD_LOCK = 2;

    logic clk = 1'b0;
    logic reset_n, data_i, data_val_i, clear_i;
    logic        locked, inverted, err_pulse;
    logic [8:0]  period_err;
    logic [31:0] bit_cnt, err_cnt;
    logic [15:0] loss_cnt;
    logic        s_locked, s_inverted, s_err_pulse;
    logic [8:0]  s_period_err;
    logic [3:0]  s_bit_cnt, s_err_cnt;
    logic [15:0] s_loss_cnt;

    always #5 clk = ~clk;

    rx_pattern_checker u_dut (
        .clk(clk), .reset_n(reset_n), .data_i(data_i), .data_val_i(data_val_i), .clear_i(clear_i),
        .locked_o(locked), .inverted_o(inverted), .err_pulse_o(err_pulse), .period_err_o(period_err),
        .bit_cnt_o(bit_cnt), .err_cnt_o(err_cnt), .loss_cnt_o(loss_cnt)
    );

    rx_pattern_checker #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .data_i(data_i), .data_val_i(data_val_i), .clear_i(clear_i),
        .locked_o(s_locked), .inverted_o(s_inverted), .err_pulse_o(s_err_pulse), .period_err_o(s_period_err),
        .bit_cnt_o(s_bit_cnt), .err_cnt_o(s_err_cnt), .loss_cnt_o(s_loss_cnt)
    );

    typedef struct {
        logic        locked, inv, pulse;
        logic [8:0]  perr;
        logic [31:0] bitc, errc;
        logic [15:0] loss;
        logic [3:0]  bit4, err4;
        int          bitno;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests, n_fail;

    // Reference model state
    bit          pat[PW];
    bit          hist[$];
    int          m_mode, m_ptr, m_pos, m_perr;
    bit          m_inv, m_pulse;
    logic [8:0]  m_perr_out;
    logic [31:0] m_bit, m_err;
    logic [15:0] m_loss;
    logic [3:0]  m_bit4, m_err4;

    // Stream / monitor bookkeeping
    int s_pos, s_bitno;
    int first_lock, first_inv, pulses;
    bit any_lock;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC_W; i++) hist.push_back(1'b0);
        m_mode = MD_SEARCH; m_ptr = 0; m_pos = 0; m_perr = 0;
        m_inv = 0; m_pulse = 0; m_perr_out = '0;
        m_bit = '0; m_err = '0; m_loss = '0; m_bit4 = '0; m_err4 = '0;
    endtask

    task automatic model_step(input bit v, input bit d, input bit c);
        int mm0, mm1, e;
        m_pulse = 1'b0;
        if (v) begin
            hist.push_back(d);
            void'(hist.pop_front());
            if (m_mode == MD_SEARCH) begin
                mm0 = 0; mm1 = 0;
                for (int i = 0; i < SYNC_W; i++) begin
                    if (hist[i] != pat[i]) mm0++;
                    else mm1++;
                end
                if (mm0 <= SYNC_ERR || mm1 <= SYNC_ERR) begin
                    m_mode = MD_VERIFY;
                    m_inv  = (mm0 > SYNC_ERR);
                    m_ptr  = SYNC_W % PW; m_pos = 0; m_perr = 0;
                end
            end else begin
                e = int'(d ^ pat[m_ptr] ^ m_inv);
                m_perr += e;
                if (m_mode == MD_LOCK) begin
                    m_pulse = (e == 1);
                    if (!c) begin
                        if (m_bit != 32'hFFFF_FFFF) m_bit++;
                        if (m_bit4 != 4'hF) m_bit4++;
                        if (e == 1 && m_err != 32'hFFFF_FFFF) m_err++;
                        if (e == 1 && m_err4 != 4'hF) m_err4++;
                    end
                end
                m_ptr = (m_ptr + 1) % PW;
                m_pos++;
                if (m_pos == PW) begin
                    m_pos = 0;
                    m_perr_out = 9'(m_perr);
                    if (m_perr > LOSS_THR) begin
                        if (m_mode == MD_LOCK && !c && m_loss != 16'hFFFF) m_loss++;
                        m_mode = MD_SEARCH;
                        m_inv  = 0;
                    end else begin
                        m_mode = MD_LOCK;
                    end
                    m_perr = 0;
                end
            end
        end
        if (c) begin
            m_bit = '0; m_err = '0; m_loss = '0; m_bit4 = '0; m_err4 = '0;
        end
    endtask

    task automatic drive(input bit v, input bit d, input bit c, input int bitno);
        exp_t e;
        @(negedge clk);
        data_val_i = v; data_i = d; clear_i = c;
        model_step(v, d, c);
        e.locked = (m_mode == MD_LOCK); e.inv = m_inv; e.pulse = m_pulse;
        e.perr = m_perr_out; e.bitc = m_bit; e.errc = m_err; e.loss = m_loss;
        e.bit4 = m_bit4; e.err4 = m_err4; e.bitno = bitno;
        sb_q.push_back(e);
    endtask

    task automatic settle();
        drive(1'b0, 1'b0, 1'b0, 0);
        @(posedge clk);
        #2;
    endtask

    task automatic send_chunk(input int n, input bit comp, input int f_start, input int f_step,
                              input int f_num, input int gap_pct, input int clr_at);
        int nf;
        bit d, fl;
        nf = 0;
        for (int j = 0; j < n; j++) begin
            while (int'($urandom_range(99)) < gap_pct) drive(1'b0, 1'($urandom_range(1)), 1'b0, 0);
            fl = (nf < f_num) && (j >= f_start) && (((j - f_start) % f_step) == 0);
            if (fl) nf++;
            d = pat[s_pos] ^ comp ^ fl;
            s_pos = (s_pos + 1) % PW;
            s_bitno++;
            drive(1'b1, d, (j == clr_at), s_bitno);
        end
    endtask

    task automatic send_prbs(input int n);
        logic [8:0] lf;
        bit b;
        lf = 9'h1FF;
        for (int j = 0; j < n; j++) begin
            b  = lf[8] ^ lf[4];
            lf = {lf[7:0], b};
            drive(1'b1, b, 1'b0, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; data_val_i = 1'b0; clear_i = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        first_lock = -1; first_inv = -1; pulses = 0; any_lock = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if ({locked, inverted, err_pulse, period_err, bit_cnt, err_cnt, loss_cnt,
                     s_locked, s_bit_cnt, s_err_cnt, s_loss_cnt} !==
                    {e.locked, e.inv, e.pulse, e.perr, e.bitc, e.errc, e.loss,
                     e.locked, e.bit4, e.err4, e.loss}) begin
                    n_fail++;
                    $display("FAIL scoreboard bit %0d: got lk=%0b inv=%0b pls=%0b per=%0d bit=%0d err=%0d loss=%0d lk4=%0b bit4=%0d err4=%0d loss4=%0d; expected lk=%0b inv=%0b pls=%0b per=%0d bit=%0d err=%0d loss=%0d bit4=%0d err4=%0d",
                             e.bitno, locked, inverted, err_pulse, period_err, bit_cnt, err_cnt, loss_cnt,
                             s_locked, s_bit_cnt, s_err_cnt, s_loss_cnt,
                             e.locked, e.inv, e.pulse, e.perr, e.bitc, e.errc, e.loss, e.bit4, e.err4);
                end
                if (locked && first_lock < 0) first_lock = e.bitno;
                if (inverted && first_inv < 0) first_inv = e.bitno;
                if (err_pulse) pulses++;
                if (locked) any_lock = 1'b1;
            end
        end
    end

    initial begin : stim
        logic [255:0] patv;
        n_tests = 0; n_fail = 0;
        patv = PAT_C;
        for (int i = 0; i < PW; i++) pat[i] = patv[PW-1-i];
        reset_n = 1'b0; data_i = 1'b0; data_val_i = 1'b0; clear_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_locked", locked, 0);
        check("rst_inverted", inverted, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_period_err", period_err, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_loss_cnt", loss_cnt, 0);
        reset_n = 1'b1;

        // Clean pattern from offset 100: verify after bit 188, lock after bit 444
        s_pos = 100; s_bitno = 0; first_lock = -1; first_inv = -1;
        send_chunk(444 + 256, 1'b0, 0, 1, 0, 0, -1);
        settle();
        check("lock_bit", first_lock, 444);
        check("normal_never_inverted", first_inv, -1);

        // Three isolated flips inside one aligned period
        pulses = 0;
        send_chunk(256, 1'b0, 20, 90, 3, 0, -1);
        settle();
        check("flip3_err_cnt", err_cnt, 3);
        check("flip3_pulses", pulses, 3);
        check("flip3_period_err", period_err, 3);
        check("flip3_locked", locked, 1);

        // Twenty flips in one period force loss, then clean data relocks
        send_chunk(256, 1'b0, 10, 5, 20, 0, -1);
        settle();
        check("flip20_period_err", period_err, 20);
        check("flip20_locked", locked, 0);
        check("flip20_loss", loss_cnt, 1);
        send_chunk(768, 1'b0, 0, 1, 0, 0, -1);
        settle();
        check("relock_locked", locked, 1);
        check("relock_loss", loss_cnt, 1);

        // Sparse errors with idle gaps: narrow counters saturate, lock held
        send_chunk(1500, 1'b0, 5, 40, 1000, 30, -1);
        settle();
        check("sat_locked", locked, 1);
        check("sat_err4", s_err_cnt, 15);
        check("sat_bit4", s_bit_cnt, 15);

        // Clear on an errored bit
        send_chunk(8, 1'b0, 3, 1, 1, 0, 3);
        settle();
        check("clear_err_cnt", err_cnt, 0);
        check("clear_bit_cnt", bit_cnt, 4);
        check("clear_locked", locked, 1);

        // Asynchronous reset while locked
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_pulse", err_pulse, 0);
        check("arst_period_err", period_err, 0);
        check("arst_bit_cnt", bit_cnt, 0);
        check("arst_err4", s_err_cnt, 0);
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;

        // Complemented stream
        s_pos = 100; s_bitno = 0; first_lock = -1; first_inv = -1;
        send_chunk(744, 1'b1, 0, 1, 0, 0, -1);
        settle();
        check("comp_inv_bit", first_inv, 188);
        check("comp_lock_bit", first_lock, 444);
        check("comp_inverted", inverted, 1);
        check("comp_err_cnt", err_cnt, 0);

        // PRBS-9 never locks
        do_reset();
        any_lock = 1'b0;
        send_prbs(10000);
        settle();
        check("prbs_any_lock", any_lock, 0);
        check("prbs_loss", loss_cnt, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
